sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one asynchronous 16-bit SRAM (active-low CE/OE/WE, bidirectional data) between two
//  requesters: port 0 (data/memory stage) and port 1 (instruction fetch). Arbitrates, then runs
//  a fixed address-setup / strobe / hold sequence for each granted access. Returns read data
//  and a one-cycle ack to the granted port.
// PARAMETERS
//  ADDR_W      16  SRAM and port address width
//  DATA_W      16  SRAM and port data width
//  ACC_CYCLES  2   cycles the OE/WE strobe is held low; legal range 1..15
//  RR_MODE     0   0 = fixed priority (port 0 wins); 1 = round-robin on contention
// PORTS
//  clk         in     1       clock; all state changes on the rising edge
//  rst         in     1       reset, asynchronous, active-low
//  p0_req      in     1       port 0 request; held high until p0_ack
//  p0_we       in     1       port 0: 1 = write, 0 = read
//  p0_addr     in     ADDR_W  port 0 address
//  p0_wdata    in     DATA_W  port 0 write data
//  p0_ack      out    1       port 0 one-cycle completion pulse
//  p0_rdata    out    DATA_W  port 0 read data; valid from the p0_ack cycle until the next p0 read
//  p1_*        (same set as p0_*, for port 1)
//  ram_addr    out    ADDR_W  SRAM address
//  ram_data    inout  DATA_W  SRAM data; driven only during write sequences, else high-Z
//  ram_ce_n    out    1       SRAM chip enable, active low
//  ram_oe_n    out    1       SRAM output enable, active low
//  ram_we_n    out    1       SRAM write enable, active low
//  busy        out    1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ram_ce_n/oe_n/we_n=1; ram_addr=0; ram_data=Z;
//   p0_ack=p1_ack=0; p0_rdata=p1_rdata=0; busy=0; last_grant=1 (port 0 wins first RR tie).
//   Reset mid-access aborts immediately: strobes deassert, data bus released, no ack issued.
//  All outputs are registered. States: IDLE, ADDR, STROBE, FINISH.
//  IDLE: if any req, grant per arbitration, latch we/addr/wdata of grantee -> ADDR.
//  ADDR (1 cycle): ram_addr=latched addr; ram_ce_n=0; strobes high; write: drive ram_data.
//  STROBE (ACC_CYCLES cycles, down-counter): read: ram_oe_n=0; write: ram_we_n=0, data driven.
//   Read data is captured from ram_data on the last STROBE cycle, before OE deasserts.
//  FINISH (1 cycle): strobes high, ram_ce_n=0, address held, write data still driven (hold);
//   grantee ack=1, its rdata updated (reads only).
//   Next: if the other port has req=1, grant it directly -> ADDR (no IDLE bubble).
//   Otherwise -> IDLE. The acked port's req is ignored in FINISH (it may still be high).
//   The other port is granted from FINISH regardless of RR_MODE.
//  Arbitration in IDLE, both req high: RR_MODE=0 -> port 0. RR_MODE=1 -> the port not in
//   last_grant. last_grant updates on every grant.
//  Latency: req seen in IDLE cycle T -> ack in cycle T+ACC_CYCLES+2. Back-to-back
//   throughput: one access per ACC_CYCLES+2 cycles.
//  ram_ce_n=1 and ram_addr holds its last value in IDLE; never OE and WE low together.
//  ram_data is driven only in ADDR/STROBE/FINISH of a write; otherwise Z.
//  Request fields must be stable while req is high. They are latched at grant, so later
//   changes do not affect an access already in progress.
// TESTING
//  1. ACC=2, p1 read 0x0040, SRAM model returns 0xBEEF -> ram_oe_n low 2 cycles,
//     p1_ack in cycle T+4, p1_rdata=0xBEEF, ram_we_n stays 1.
//  2. p0 write 0x1234 to 0x0100 -> ram_we_n low exactly 2 cycles; ram_data=0x1234 from ADDR
//     through FINISH, then Z; SRAM model holds 0x1234.
//  3. RR_MODE=0, p0 and p1 req in same cycle -> p0 acked first; p1 granted from FINISH;
//     p1_ack arrives 4 cycles after p0_ack.
//  4. RR_MODE=1, both ports request continuously for 4 accesses -> grants p0,p1,p0,p1.
//  5. rst low during STROBE of a write -> same cycle: ram_we_n=1, ram_data=Z, no ack;
//     after release, state IDLE.
//  6. Sweep ACC_CYCLES=1 and 15 -> strobe width equals ACC_CYCLES;
//     ack latency = ACC_CYCLES+2 cycles.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for one SRAM arbiter port: request fields in, ack and read data back.
// No latency of its own; it is pure wiring.
// The requester holds req and its fields steady until ack; there is no other backpressure.
interface sram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input  ack, rdata);
   modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// Two requesters share one async SRAM through an address-setup / strobe / hold sequence per access.
// An ack arrives ACC_CYCLES+2 cycles after a request is seen in IDLE; back-to-back accesses run one per ACC_CYCLES+2 cycles.
// A requester keeps req high until its one-cycle ack; the other port is served straight from FINISH.
module sram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int ACC_CYCLES = 2,
   parameter int RR_MODE    = 0
) (
   input  logic              clk,
   input  logic              rst,
   sram_arbiter_if.slave     p0,
   sram_arbiter_if.slave     p1,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ADDR, STROBE, FINISH} state_t;

   state_t            state, state_nx;
   logic [3:0]        cnt;         // strobe cycles remaining after the current one
   logic              gnt;         // port that owns the current access
   logic              gnt_nx;
   logic              grant;       // a new access is granted at this edge
   logic              last_grant;
   logic              we_l;
   logic              we_nx;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] wdata_q;
   logic              data_oe;

   // Write data goes on the bus for the whole of a write sequence only.
   assign ram_data = data_oe ? wdata_q : {DATA_W{1'bz}};

   // Request fields of whichever port is being granted.
   assign sel_we    = gnt_nx ? p1.we    : p0.we;
   assign sel_addr  = gnt_nx ? p1.addr  : p0.addr;
   assign sel_wdata = gnt_nx ? p1.wdata : p0.wdata;
   assign we_nx     = grant ? sel_we : we_l;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state and arbitration. FINISH hands over to the other port without passing through IDLE.
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      gnt_nx   = gnt;
      case (state)
         IDLE: begin
            if (p0.req || p1.req) begin
               grant    = 1'b1;
               state_nx = ADDR;
               if (RR_MODE != 0 && p0.req && p1.req) gnt_nx = ~last_grant;
               else                                  gnt_nx = ~p0.req;
            end
         end
         ADDR:   state_nx = STROBE;
         STROBE: if (cnt == '0) state_nx = FINISH;
         FINISH: begin
            state_nx = IDLE;
            if (gnt ? p0.req : p1.req) begin
               grant    = 1'b1;
               gnt_nx   = ~gnt;
               state_nx = ADDR;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Grant bookkeeping, strobe counter and latched request fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         we_l       <= 1'b0;
         wdata_q    <= '0;
         ram_addr   <= '0;
         cnt        <= '0;
      end else begin
         if (grant) begin
            gnt        <= gnt_nx;
            last_grant <= gnt_nx;
            we_l       <= sel_we;
            wdata_q    <= sel_wdata;
            ram_addr   <= sel_addr;
         end
         if (state == ADDR)                  cnt <= 4'(ACC_CYCLES - 1);
         else if (state == STROBE && cnt != '0) cnt <= cnt - 4'd1;
      end
   end

   // Registered SRAM controls, acks and read data, all derived from the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_ce_n <= 1'b1;
         ram_oe_n <= 1'b1;
         ram_we_n <= 1'b1;
         data_oe  <= 1'b0;
         busy     <= 1'b0;
         p0.ack   <= 1'b0;
         p1.ack   <= 1'b0;
         p0.rdata <= '0;
         p1.rdata <= '0;
      end else begin
         ram_ce_n <= (state_nx == IDLE);
         ram_oe_n <= !(state_nx == STROBE && !we_nx);
         ram_we_n <= !(state_nx == STROBE && we_nx);
         data_oe  <= (state_nx != IDLE) && we_nx;
         busy     <= (state_nx != IDLE);
         p0.ack   <= (state_nx == FINISH) && !gnt;
         p1.ack   <= (state_nx == FINISH) && gnt;
         // Sample on the last strobe cycle, while OE is still low.
         if (state == STROBE && cnt == '0 && !we_l) begin
            if (gnt) p1.rdata <= ram_data;
            else     p0.rdata <= ram_data;
         end
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: four arbiter instances (ACC/RR = 2/0, 2/1, 1/0, 15/0), each with a small SRAM model.
// Reads return 0xBEEF at 0x0040 and ~addr elsewhere; writes are captured while CE and WE are low.
// A probe drives 0 onto an idle bus so a released bus reads back as 0.
module tb_sram_arbiter;
   logic        clk;
   logic        rst;
   logic        probe_en;
   logic        p0_req [4], p0_we [4], p0_ack [4];
   logic        p1_req [4], p1_we [4], p1_ack [4];
   logic [15:0] p0_addr [4], p0_wdata [4], p0_rdata [4];
   logic [15:0] p1_addr [4], p1_wdata [4], p1_rdata [4];
   logic [15:0] ram_addr [4], ram_obs [4], wr_dat [4], wr_adr [4];
   logic        ram_ce_n [4], ram_oe_n [4], ram_we_n [4], busy [4];
   int          errs = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : lane
      wire  [15:0] bus;
      logic [15:0] wmem, waddr;
      sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if0 ();
      sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
      assign if0.req = p0_req[g];  assign if0.we = p0_we[g];
      assign if0.addr = p0_addr[g]; assign if0.wdata = p0_wdata[g];
      assign if1.req = p1_req[g];  assign if1.we = p1_we[g];
      assign if1.addr = p1_addr[g]; assign if1.wdata = p1_wdata[g];
      assign p0_ack[g] = if0.ack;  assign p0_rdata[g] = if0.rdata;
      assign p1_ack[g] = if1.ack;  assign p1_rdata[g] = if1.rdata;

      sram_arbiter #(
         .ADDR_W(16), .DATA_W(16),
         .ACC_CYCLES(g == 2 ? 1 : (g == 3 ? 15 : 2)),
         .RR_MODE(g == 1 ? 1 : 0)
      ) dut (
         .clk(clk), .rst(rst), .p0(if0.slave), .p1(if1.slave),
         .ram_addr(ram_addr[g]), .ram_data(bus), .ram_ce_n(ram_ce_n[g]),
         .ram_oe_n(ram_oe_n[g]), .ram_we_n(ram_we_n[g]), .busy(busy[g])
      );

      assign bus = (!ram_ce_n[g] && !ram_oe_n[g])
                   ? ((ram_addr[g] == 16'h0040) ? 16'hBEEF : ~ram_addr[g])
                   : (probe_en ? 16'h0000 : 16'hzzzz);
      assign ram_obs[g] = bus;

      // SRAM model write capture.
      always @(posedge clk) begin
         if (!ram_ce_n[g] && !ram_we_n[g]) begin
            wmem  <= bus;
            waddr <= ram_addr[g];
         end
      end
      assign wr_dat[g] = wmem;
      assign wr_adr[g] = waddr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One access on one port; counts cycles to ack and strobe widths, checks write data while busy.
   task automatic access(input int ln, input bit port, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, output int lat, output int oe_w, output int we_w,
                         output bit drv_ok, output bit overlap);
      if (port) begin p1_we[ln] = wr; p1_addr[ln] = a; p1_wdata[ln] = d; p1_req[ln] = 1'b1; end
      else      begin p0_we[ln] = wr; p0_addr[ln] = a; p0_wdata[ln] = d; p0_req[ln] = 1'b1; end
      lat = 0; oe_w = 0; we_w = 0; drv_ok = 1'b1; overlap = 1'b0;
      while (lat < 40) begin
         tick();
         lat++;
         if (!ram_oe_n[ln]) oe_w++;
         if (!ram_we_n[ln]) we_w++;
         if (!ram_oe_n[ln] && !ram_we_n[ln]) overlap = 1'b1;
         if (wr && busy[ln] && ram_obs[ln] !== d) drv_ok = 1'b0;
         if (port ? p1_ack[ln] : p0_ack[ln]) break;
      end
      if (port) p1_req[ln] = 1'b0; else p0_req[ln] = 1'b0;
   endtask

   // Both ports request a read in the same cycle; returns the cycle of each ack.
   task automatic tie(input int ln, input logic [15:0] a0, input logic [15:0] a1,
                      output int t0, output int t1);
      p0_we[ln] = 1'b0; p1_we[ln] = 1'b0; p0_addr[ln] = a0; p1_addr[ln] = a1;
      p0_req[ln] = 1'b1; p1_req[ln] = 1'b1;
      t0 = 0; t1 = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (p0_ack[ln]) begin t0 = t; p0_req[ln] = 1'b0; end
         if (p1_ack[ln]) begin t1 = t; p1_req[ln] = 1'b0; end
         if (t0 != 0 && t1 != 0) break;
      end
      p0_req[ln] = 1'b0; p1_req[ln] = 1'b0;
   endtask

   initial begin
      int lat, oe_w, we_w, t0, t1, n, acc;
      bit drv_ok, overlap;
      int order [4];
      int when [4];

      rst = 1'b0; probe_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         p0_req[i] = 0; p0_we[i] = 0; p0_addr[i] = '0; p0_wdata[i] = '0;
         p1_req[i] = 0; p1_we[i] = 0; p1_addr[i] = '0; p1_wdata[i] = '0;
         order[i] = -1; when[i] = 0;
      end
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_ce_n[%0d]", i), ram_ce_n[i], 1'b1);
         chk($sformatf("rst_strobes[%0d]", i), {ram_oe_n[i], ram_we_n[i]}, 2'b11);
         chk($sformatf("rst_addr[%0d]", i), ram_addr[i], 16'h0000);
         chk($sformatf("rst_busy_ack[%0d]", i), {busy[i], p0_ack[i], p1_ack[i]}, 3'b000);
         chk($sformatf("rst_rdata[%0d]", i), {p0_rdata[i], p1_rdata[i]}, 32'h0);
      end
      rst = 1'b1;
      tick();

      // p1 read of 0x0040 on the ACC=2 fixed-priority lane.
      access(0, 1'b1, 1'b0, 16'h0040, 16'h0000, lat, oe_w, we_w, drv_ok, overlap);
      chk("rd_latency", lat, 4);
      chk("rd_oe_width", oe_w, 2);
      chk("rd_we_idle", we_w, 0);
      chk("rd_p1_rdata", p1_rdata[0], 16'hBEEF);

      // p0 write of 0x1234 to 0x0100.
      access(0, 1'b0, 1'b1, 16'h0100, 16'h1234, lat, oe_w, we_w, drv_ok, overlap);
      chk("wr_latency", lat, 4);
      chk("wr_we_width", we_w, 2);
      chk("wr_oe_idle", oe_w, 0);
      chk("wr_data_driven", drv_ok, 1'b1);
      tick();
      probe_en = 1'b1; #1;
      chk("wr_bus_released", ram_obs[0], 16'h0000);
      probe_en = 1'b0;
      chk("wr_mem_data", wr_dat[0], 16'h1234);
      chk("wr_mem_addr", wr_adr[0], 16'h0100);
      chk("rdata_held", p1_rdata[0], 16'hBEEF);
      chk("idle_ce_n", ram_ce_n[0], 1'b1);
      chk("idle_addr_hold", ram_addr[0], 16'h0100);

      // Fixed priority tie: p0 first, p1 straight from FINISH.
      tick();
      tie(0, 16'h0010, 16'h0020, t0, t1);
      chk("fp_p0_ack_t", t0, 4);
      chk("fp_p1_ack_t", t1, 8);
      chk("fp_p0_rdata", p0_rdata[0], 16'hFFEF);
      chk("fp_p1_rdata", p1_rdata[0], 16'hFFDF);

      // Round-robin lane: continuous requests from both ports.
      tick();
      p0_we[1] = 1'b0; p1_we[1] = 1'b0; p0_addr[1] = 16'h0001; p1_addr[1] = 16'h0002;
      p0_req[1] = 1'b1; p1_req[1] = 1'b1;
      n = 0;
      for (int t = 1; t <= 60 && n < 4; t++) begin
         tick();
         if (p0_ack[1] && n < 4) begin order[n] = 0; when[n] = t; n++; end
         if (p1_ack[1] && n < 4) begin order[n] = 1; when[n] = t; n++; end
      end
      p0_req[1] = 1'b0; p1_req[1] = 1'b0;
      chk("rr_count", n, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_order[%0d]", i), order[i], i % 2);
         chk($sformatf("rr_time[%0d]", i), when[i], 4 * (i + 1));
      end
      tick(); tick();
      chk("rr_idle_busy", busy[1], 1'b0);
      // Last grant was p0 after this lone access, so the next tie goes to p1.
      access(1, 1'b0, 1'b0, 16'h0003, 16'h0000, lat, oe_w, we_w, drv_ok, overlap);
      chk("rr_lone_latency", lat, 4);
      tick();
      tie(1, 16'h0004, 16'h0005, t0, t1);
      chk("rr_tie_p1_t", t1, 4);
      chk("rr_tie_p0_t", t0, 8);

      // Strobe width and latency at ACC_CYCLES 1 and 15.
      for (int ln = 2; ln < 4; ln++) begin
         acc = (ln == 2) ? 1 : 15;
         tick();
         access(ln, 1'b0, 1'b0, 16'h0300, 16'h0000, lat, oe_w, we_w, drv_ok, overlap);
         chk($sformatf("acc%0d_rd_latency", acc), lat, acc + 2);
         chk($sformatf("acc%0d_rd_oe_width", acc), oe_w, acc);
         chk($sformatf("acc%0d_rd_rdata", acc), p0_rdata[ln], 16'hFCFF);
         tick();
         access(ln, 1'b1, 1'b1, 16'h0301, 16'hA0A0, lat, oe_w, we_w, drv_ok, overlap);
         chk($sformatf("acc%0d_wr_latency", acc), lat, acc + 2);
         chk($sformatf("acc%0d_wr_we_width", acc), we_w, acc);
         chk($sformatf("acc%0d_wr_driven", acc), drv_ok, 1'b1);
         chk($sformatf("acc%0d_no_overlap", acc), overlap, 1'b0);
      end

      // Reset in the middle of a write strobe.
      tick();
      p0_we[0] = 1'b1; p0_addr[0] = 16'h0200; p0_wdata[0] = 16'h5A5A; p0_req[0] = 1'b1;
      tick(); tick();
      chk("rst_pre_we_low", ram_we_n[0], 1'b0);
      rst = 1'b0; probe_en = 1'b1;
      #1;
      chk("rst_mid_we_n", ram_we_n[0], 1'b1);
      chk("rst_mid_bus_z", ram_obs[0], 16'h0000);
      chk("rst_mid_no_ack", p0_ack[0], 1'b0);
      chk("rst_mid_ce_busy", {ram_ce_n[0], busy[0]}, 2'b10);
      p0_req[0] = 1'b0; probe_en = 1'b0;
      tick();
      rst = 1'b1;
      tick(); tick();
      chk("rst_after_idle", {busy[0], ram_ce_n[0], p0_ack[0]}, 3'b010);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
